// File: rtl/dmem_pkg.sv
// Shared types, mask encodings and access-legality helper for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Only byte, naturally aligned half and naturally aligned word accesses are legal.
  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] addr_lo);
    logic ok;
    case (mask)
      MASK_B:  ok = 1'b1;
      MASK_H:  ok = ~addr_lo[0];
      MASK_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-requester request/response channel between a memory master and the arbiter.
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way arbiter: round-robin on last_grant, or m0-first when fixed_prio is set.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      if (fixed_prio || last_grant) begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
      end else begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
      end
    end else if (req[0]) begin
      gnt     = 2'b01;
      gnt_idx = 1'b0;
    end else if (req[1]) begin
      gnt     = 2'b10;
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between two masters through an IDLE->ACCESS->RESP sequence,
// rejecting misaligned, badly masked or out-of-range accesses before they reach memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [3:0]  mem_rmask,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  arb_gnt;
  logic        arb_idx;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  logic        sel_legal;
  logic        sel_rsp_ready;

  rr_arb2 u_arb (
    .req        ({m1.req_valid, m0.req_valid}),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign sel_we        = arb_idx ? m1.req_we    : m0.req_we;
  assign sel_addr      = arb_idx ? m1.req_addr  : m0.req_addr;
  assign sel_wdata     = arb_idx ? m1.req_wdata : m0.req_wdata;
  assign sel_mask      = arb_idx ? m1.req_mask  : m0.req_mask;
  assign sel_legal     = mask_legal(sel_mask, sel_addr[1:0]) && ((sel_addr >> ADDR_W) == 32'd0);
  assign sel_rsp_ready = gnt_q ? m1.rsp_ready : m0.rsp_ready;

  assign m0.req_ready = (state_q == IDLE) && arb_gnt[0];
  assign m1.req_ready = (state_q == IDLE) && arb_gnt[1];
  assign m0.rsp_valid = (state_q == RESP) && !gnt_q;
  assign m1.rsp_valid = (state_q == RESP) &&  gnt_q;
  assign m0.rsp_rdata = m0.rsp_valid ? rdata_q : 32'd0;
  assign m1.rsp_rdata = m1.rsp_valid ? rdata_q : 32'd0;
  assign m0.rsp_err   = m0.rsp_valid && err_q;
  assign m1.rsp_err   = m1.rsp_valid && err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    rdata_d      = rdata_q;
    mem_ce       = 1'b0;
    mem_we       = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_wmask    = 4'd0;
    mem_rmask    = 4'd0;

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          gnt_d        = arb_idx;
          last_grant_d = arb_idx;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          mask_d       = sel_mask;
          rdata_d      = 32'd0;
          err_d        = ~sel_legal;
          // Illegal requests skip the memory cycle entirely and answer with an error.
          state_d      = sel_legal ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_ce    = 1'b1;
        mem_we    = we_q;
        mem_rd    = ~we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = we_q ? mask_q : 4'd0;
        mem_rmask = we_q ? 4'd0 : mask_q;
        rdata_d   = we_q ? 32'd0 : mem_rdata;
        state_d   = RESP;
      end
      RESP: begin
        if (sel_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
    end
  end

  // Payload registers are only observed through state-gated outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, response scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  logic        mem_ce, mem_we, mem_rd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask, mem_rmask;

  dmem_arbiter #(.ADDR_W(12), .FIXED_PRIO(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rmask (mem_rmask),
    .mem_rdata (mem_rdata)
  );

  // Behavioural memory: preloaded on the first edge, byte-lane writes, combinational read.
  logic [31:0] mem [0:1023];
  bit mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[0]    <= 32'h0000_1111;
      mem[1]    <= 32'h4444_4444;
      mem[8]    <= 32'h1122_3344;
      mem[12]   <= 32'hCAFE_0030;
      mem[1023] <= 32'hA5A5_A5A5;
      mem_init  <= 1'b1;
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_cnt = 0;
  int   we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Response scoreboard and per-cycle protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m0_if.rsp_valid && m0_if.rsp_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_unexpected_rsp: rdata 0x%08h err %0b with nothing pending", m0_if.rsp_rdata, m0_if.rsp_err);
        end else begin
          e = q0.pop_front();
          chk("m0_rsp_rdata", m0_if.rsp_rdata, e.rdata);
          chk("m0_rsp_err", 32'(m0_if.rsp_err), 32'(e.err));
        end
      end
      if (m1_if.rsp_valid && m1_if.rsp_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_unexpected_rsp: rdata 0x%08h err %0b with nothing pending", m1_if.rsp_rdata, m1_if.rsp_err);
        end else begin
          e = q1.pop_front();
          chk("m1_rsp_rdata", m1_if.rsp_rdata, e.rdata);
          chk("m1_rsp_err", 32'(m1_if.rsp_err), 32'(e.err));
        end
      end
      if (m0_if.req_ready || m1_if.req_ready)
        chk("single_grant", 32'(m0_if.req_ready & m1_if.req_ready), 32'd0);
      if (m0_if.rsp_valid || m1_if.rsp_valid)
        chk("single_rsp", 32'(m0_if.rsp_valid & m1_if.rsp_valid), 32'd0);
      if (mem_ce) ce_cnt++;
      if (mem_ce && mem_we) we_cnt++;
      if (m0_if.req_valid && m0_if.req_ready) grant_log.push_back(0);
      if (m1_if.req_valid && m1_if.req_ready) grant_log.push_back(1);
    end
  end

  task automatic drive(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] er, input logic ee, input bit push);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    if (m == 0) begin
      if (push) q0.push_back(e);
      m0_if.req_we = we; m0_if.req_addr = addr; m0_if.req_wdata = wdata; m0_if.req_mask = mask;
      m0_if.req_valid = 1'b1;
    end else begin
      if (push) q1.push_back(e);
      m1_if.req_we = we; m1_if.req_addr = addr; m1_if.req_wdata = wdata; m1_if.req_mask = mask;
      m1_if.req_valid = 1'b1;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_if.req_ready : m1_if.req_ready;
  endfunction

  task automatic drop(input int m);
    if (m == 0) m0_if.req_valid = 1'b0;
    else        m1_if.req_valid = 1'b0;
  endtask

  task automatic wait_accept(input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(m) && n < 50);
    if (!rdy(m)) begin
      checks++; errors++;
      $display("FAIL accept_timeout_m%0d: ready low for %0d cycles, want high", m, n);
    end
    @(posedge clk); #1;
    drop(m);
  endtask

  task automatic send(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input logic [31:0] er, input logic ee);
    @(posedge clk); #1;
    drive(m, we, addr, wdata, mask, er, ee, 1'b1);
    wait_accept(m);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending m0=%0d m1=%0d, want 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({m0_if.req_ready, m1_if.req_ready, m0_if.rsp_valid, m1_if.rsp_valid,
                             m0_if.rsp_err, m1_if.rsp_err, mem_ce, mem_we, mem_rd}), 32'd0);
    chk({tag, "_data"}, mem_addr | mem_wdata | m0_if.rsp_rdata | m1_if.rsp_rdata |
                        32'({mem_wmask, mem_rmask}), 32'd0);
  endtask

  vec_t vecs[16];
  int   exp_ce, exp_we, ce_snap;

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1, 1'b0, 32'h0000_0006, 32'h0,         4'b1111, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1, 1'b0, 32'h0000_1002, 32'h0,         4'b1111, 32'h0000_0000, 1'b1};
    vecs[4]  = '{0, 1'b1, 32'h0000_0020, 32'h0000_00AB, 4'b0001, 32'h0000_0000, 1'b0};
    vecs[5]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'b1111, 32'h1122_33AB, 1'b0};
    vecs[6]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'b0101, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1, 1'b1, 32'h0000_0040, 32'h0000_BEEF, 4'b0011, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1, 1'b0, 32'h0000_0042, 32'h0,         4'b0011, 32'h0000_BEEF, 1'b0};
    vecs[9]  = '{0, 1'b0, 32'h0000_0043, 32'h0,         4'b0011, 32'h0000_0000, 1'b1};
    vecs[10] = '{1, 1'b0, 32'h0000_0041, 32'h0,         4'b0001, 32'h0000_BEEF, 1'b0};
    vecs[11] = '{0, 1'b1, 32'h0000_0050, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{0, 1'b0, 32'h0000_0050, 32'h0,         4'b1111, 32'h0000_0000, 1'b0};
    vecs[13] = '{1, 1'b1, 32'h0000_0052, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[14] = '{1, 1'b0, 32'h8000_0000, 32'h0,         4'b0001, 32'h0000_0000, 1'b1};
    vecs[15] = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         4'b1111, 32'hA5A5_A5A5, 1'b0};

    m0_if.req_valid = 1'b0; m0_if.req_we = 1'b0; m0_if.req_addr = '0; m0_if.req_wdata = '0;
    m0_if.req_mask = '0;    m0_if.rsp_ready = 1'b1;
    m1_if.req_valid = 1'b0; m1_if.req_we = 1'b0; m1_if.req_addr = '0; m1_if.req_wdata = '0;
    m1_if.req_mask = '0;    m1_if.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;

    // Both masters stream loads; m0 must win first, then grants alternate.
    fork
      begin
        for (int i = 0; i < 3; i++) send(0, 1'b0, 32'h0, 32'h0, 4'b1111, 32'h0000_1111, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) send(1, 1'b0, 32'h4, 32'h0, 4'b1111, 32'h4444_4444, 1'b0);
      end
    join
    drain();
    chk("grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Vector table, one access at a time.
    @(negedge clk);
    ce_cnt = 0; we_cnt = 0; exp_ce = 0; exp_we = 0;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
           vecs[i].exp_rdata, vecs[i].exp_err);
      drain();
      if (!vecs[i].exp_err) begin
        exp_ce++;
        if (vecs[i].we) exp_we++;
      end
    end
    chk("table_ce_cycles", 32'(ce_cnt), 32'(exp_ce));
    chk("table_we_cycles", 32'(we_cnt), 32'(exp_we));

    // Load timing: ACCESS one cycle after accept, response on the next.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk); chk("lat_ld_ready", 32'(rdy(0)), 32'd1);
    @(posedge clk); #1; drop(0);
    @(negedge clk);
    chk("lat_ld_access", 32'({mem_ce, mem_we, mem_rd, m0_if.rsp_valid}), 32'b1010);
    chk("lat_ld_masks", 32'({mem_rmask, mem_wmask}), 32'hF0);
    chk("lat_ld_addr", mem_addr, 32'h10);
    @(negedge clk); chk("lat_ld_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
    @(negedge clk); chk("lat_ld_idle", 32'({mem_ce, m0_if.rsp_valid}), 32'd0);
    drain();

    // Store timing and memory pin values.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0, 1'b1);
    @(negedge clk); chk("lat_st_ready", 32'(rdy(0)), 32'd1);
    @(posedge clk); #1; drop(0);
    @(negedge clk);
    chk("lat_st_access", 32'({mem_ce, mem_we, mem_rd}), 32'b110);
    chk("lat_st_masks", 32'({mem_wmask, mem_rmask}), 32'hF0);
    chk("lat_st_wdata", mem_wdata, 32'h0BAD_F00D);
    @(negedge clk); chk("lat_st_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
    drain();
    send(0, 1'b0, 32'h14, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b0);
    drain();

    // Illegal request answers one cycle after accept without touching memory.
    ce_snap = ce_cnt;
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h6, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b1);
    @(negedge clk); chk("err_ready", 32'(rdy(1)), 32'd1);
    @(posedge clk); #1; drop(1);
    @(negedge clk);
    chk("err_rsp", 32'({m1_if.rsp_valid, m1_if.rsp_err, mem_ce}), 32'b110);
    drain();
    chk("err_no_ce", 32'(ce_cnt), 32'(ce_snap));

    // Response back-pressure: stable response, m1 stalled until released.
    @(posedge clk); #1;
    m0_if.rsp_ready = 1'b0;
    drive(0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk); chk("hold_accept", 32'(rdy(0)), 32'd1);
    @(posedge clk); #1; drop(0);
    drive(1, 1'b0, 32'h4, 32'h0, 4'b1111, 32'h4444_4444, 1'b0, 1'b1);
    @(negedge clk); chk("hold_m1_ready_access", 32'(m1_if.req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'({m0_if.rsp_valid, m1_if.rsp_valid}), 32'b10);
      chk("hold_rsp_rdata", m0_if.rsp_rdata, 32'hDEAD_BEEF);
      chk("hold_m1_ready", 32'(m1_if.req_ready), 32'd0);
    end
    @(posedge clk); #1; m0_if.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_m1_granted", 32'({m1_if.req_ready, m0_if.rsp_valid}), 32'b10);
    @(posedge clk); #1; drop(1);
    drain();

    // Reset in the middle of a store's ACCESS cycle.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h30, 32'h5555_5555, 4'b1111, 32'h0, 1'b0, 1'b0);
    @(negedge clk); chk("rst_st_ready", 32'(rdy(0)), 32'd1);
    @(posedge clk); #1; drop(0);
    #1; chk("rst_st_ce_before", 32'({mem_ce, mem_we}), 32'b11);
    #1; rst_n = 1'b0;
    #1; chk_all_zero("rst_mid_access");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 1'b0, 32'h30, 32'h0, 4'b1111, 32'hCAFE_0030, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: m0 (CPU MEM stage) and m1 (DMA/debug loader).
- Per requester: valid/ready request channel and valid/ready response channel.
- Drives the memory's ce/we/read-enable/addr/wdata/mask pins. Memory read is combinational; memory write commits at posedge.
- Sequences every access through a registered IDLE→ACCESS→RESP flow and rejects misaligned or out-of-range accesses before they reach memory.

Parameters:
- ADDR_W, 12: byte-address width decoded by memory (4 KB); any set bit in req_addr[31:ADDR_W] is out of range.
- FIXED_PRIO, 0: 0 = round-robin between m0/m1; 1 = m0 always wins.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mN_req_valid  in  1  (N=0,1) request present
- mN_req_ready  out  1  request accepted this cycle
- mN_req_we  in  1  1 = store, 0 = load
- mN_req_addr  in  32  byte address
- mN_req_wdata  in  32  store data
- mN_req_mask  in  4  0001 byte, 0011 half, 1111 word
- mN_rsp_valid  out  1  response present
- mN_rsp_ready  in  1  response consumed
- mN_rsp_rdata  out  32  load data (0 for stores/errors)
- mN_rsp_err  out  1  misaligned/out-of-range/illegal mask
- mem_ce, mem_we, mem_rd  out  1 each  memory enables
- mem_addr, mem_wdata  out  32 each  memory address/data
- mem_wmask, mem_rmask  out  4 each  memory masks
- mem_rdata  in  32  combinational read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (so m0 wins first), all outputs 0.
  - Assertion during ACCESS drops mem_ce at once, so no write commits.
  - An outstanding response is discarded.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate among valid requesters. FIXED_PRIO=0: if both valid, grant the one not in last_grant; else grant the sole valid one.
  - mN_req_ready=1 combinationally only for the granted master, only in IDLE.
  - On handshake: latch we/addr/wdata/mask/grant into registers and update last_grant.
  - Legal request → ACCESS. Illegal request → RESP with err=1; memory untouched.
- Legality rules:
  - mask ∉ {0001,0011,1111} → err.
  - mask 1111 with addr[1:0]≠0 → err.
  - mask 0011 with addr[0]≠0 → err.
  - addr[31:ADDR_W]≠0 → err.
- ACCESS (exactly 1 cycle):
  - mem_ce=1, mem_we=latched we, mem_rd=~we, mem_addr/mem_wdata from registers.
  - mem_wmask=mask when we=1, else 0. mem_rmask=mask when we=0, else 0.
  - At the closing edge: a store commits in memory; a load captures mem_rdata into the rdata register.
  - Next state is RESP. All mem_* outputs are 0 in every state other than ACCESS.
- RESP:
  - Granted master sees mN_rsp_valid=1 with rdata/err registered and stable.
  - Hold until mN_rsp_ready=1, then → IDLE; the other master's rsp_valid stays 0.
  - rsp_ready high on the first RESP cycle gives 3-cycle latency from acceptance to IDLE.
- Throughput: max one access per 3 cycles. No new request is accepted while in ACCESS or RESP (req_ready=0).
- Simultaneous events:
  - Both masters valid in IDLE → exactly one ready.
  - The loser's request must stay valid and unchanged; it is granted on the next IDLE cycle.
  - rsp_ready asserted outside RESP is ignored.
- Stores return rsp_rdata=0, err=0 on success.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111
  - function mask_legal(mask, addr[1:0])
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, fixed_prio.
  - Outputs: one-hot gnt, gnt_idx. Purely combinational.
  - The last_grant register stays in dmem_arbiter.

Test Plan:
- m0 store: addr=0x10, wdata=0xDEADBEEF, mask=1111; then m0 load addr=0x10 → mem_ce/mem_we high exactly one cycle; load rsp_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- m0 and m1 both valid continuously with loads from 0x0 and 0x4 → grants alternate m0,m1,m0,m1; each sees the correct word; no double grant.
- m1 load addr=0x6, mask=1111 → rsp_err=1 one cycle after accept, mem_ce never asserted; m1 load addr=0x1002 → err=1 (out of range).
- m0 byte store 0xAB to addr 0x20 holding 0x11223344, then word load → 0x112233AB; mask=0101 → err=1.
- Hold m0_rsp_ready=0 for 5 cycles in RESP → rsp_valid/rdata stable, m1_req_ready stays 0; release → IDLE next cycle, m1 granted.
- Assert rst_n=0 mid-ACCESS of a store to 0x30 → all outputs 0 immediately, memory at 0x30 unchanged after release.
